emissions_monitor_mc: RTL and testbench
=======================================

Name: emissions_monitor_mc

Overview:
- Multi-channel, parametrised emissions monitor. It generalises the single-sensor IDLE/MONITOR classifier to NUM_CH gas channels.
- Adds configurable thresholds, persistence filtering on escalation, hysteresis on de-escalation, registered per-channel flags and a saturating count of critical events.
- Sits between the sensor sampling front-end and the vehicle alert/diagnostic logic.

Parameters:
- DATA_W, 8: width of each channel sample (unsigned).
- NUM_CH, 4: number of sensor channels.
- WARN_TH, 50: a sample >= WARN_TH classifies as WARN.
- CRIT_TH, 100: a sample >= CRIT_TH classifies as CRIT. Must satisfy CRIT_TH > WARN_TH.
- HYST, 5: de-escalation margin below a threshold. Must satisfy HYST <= WARN_TH.
- PERSIST, 3: consecutive valid samples required to escalate. Must be >= 1.
- CNT_W, 16: width of the critical-event counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  monitoring enable.
- sample_valid  in  1  qualifies sample_data for one cycle.
- sample_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- ack  in  NUM_CH  per-channel critical acknowledge pulse. Used only with the optional feature.
- monitoring  out  1  high while the top FSM is in MONITOR.
- warning  out  NUM_CH  channel i is in state WARN.
- critical  out  NUM_CH  channel i is in state CRIT.
- any_warning  out  1  OR of warning.
- any_critical  out  1  OR of critical.
- crit_events  out  CNT_W  saturating count of channel entries into CRIT.

Behaviour:
- Reset:
  - Top FSM goes to IDLE; all channels go to NORMAL.
  - Persistence counters go to 0, crit_events to 0, and every output to 0.
- Top FSM:
  - IDLE -> MONITOR on the first edge with enable=1.
  - MONITOR -> IDLE on any edge with enable=0.
  - On entering IDLE, every channel goes to NORMAL and its counter clears. crit_events holds its value; only reset clears it.
  - Samples are evaluated only in MONITOR. The sample on the IDLE->MONITOR edge is ignored.
- Classification (combinational, per channel): raw = CRIT if s >= CRIT_TH, else WARN if s >= WARN_TH, else NORMAL. Ordering is NORMAL < WARN < CRIT.
- Per-channel state update happens only on edges with sample_valid=1 in MONITOR. On all other edges the state and counter hold.
- Escalation (raw > state):
  - The counter increments.
  - When the incremented value equals PERSIST, state <= raw of that sample and the counter clears. A direct NORMAL->CRIT transition is allowed.
- De-escalation:
  - From CRIT: if s < CRIT_TH-HYST, go to NORMAL when s < WARN_TH-HYST, otherwise go to WARN.
  - From WARN: if s < WARN_TH-HYST, go to NORMAL.
  - The counter clears on any de-escalation.
- Hold: a sample with raw <= state that does not meet the de-escalation condition (the hysteresis band) leaves the state unchanged and clears the counter.
- Outputs:
  - warning, critical and the any_* flags are registered decodes of the state.
  - Latency is 1 cycle from the deciding sample edge to the output change.
  - monitoring is registered from the top state.
- crit_events:
  - Adds the popcount of channels entering CRIT on that edge.
  - Saturates at 2^CNT_W-1 and never wraps.
- Simultaneous enable=0 and sample_valid=1: the disable takes priority and the sample is discarded.
- Synchronous reset asserted mid-operation overrides everything on that edge.

Optional Feature:
- Macro: EMISSIONS_CRIT_LATCH_EN.
- Defined:
  - CRIT is sticky. De-escalation out of CRIT requires ack[i] to have been seen since CRIT entry, plus a qualifying sample.
  - The ack is recorded in a per-channel ack_seen bit. ack_seen is cleared on CRIT entry, on IDLE entry and on reset.
  - An ack while the channel is not in CRIT is ignored.
  - An ack on the same edge as a qualifying sample de-escalates immediately.
- Undefined: the ack port is present but ignored, and CRIT de-escalates on hysteresis alone.

Decomposition:
- Package emissions_pkg:
  - level_t enum (NORMAL=2'b00, WARN=2'b01, CRIT=2'b10) and top_state_t enum (IDLE, MONITOR).
  - classify(sample, warn_th, crit_th) function.
- Sub-module emissions_channel:
  - Per-channel FSM, persistence counter and ack_seen bit.
  - Outputs a registered level and a one-cycle crit_entry pulse.
  - Instantiated NUM_CH times by a generate loop.
- The top level holds the top FSM, output OR-reduction and the saturating counter.

Test Plan (defaults; PERSIST=3, WARN_TH=50, CRIT_TH=100, HYST=5):
- Reset, then enable=1, then three valid samples of 60 on ch0 -> warning[0]=1 one cycle after the third sample; crit_events=0.
- ch1 samples 120,120,40,120 -> counter restarts after 40, so no escalation; a further 120,120 gives critical[1]=1 after the third consecutive 120 and crit_events=1.
- ch0 in WARN, then sample 47 -> stays WARN; sample 44 -> NORMAL one cycle later.
- ch2 in CRIT, then sample 30 -> NORMAL directly; sample 97 instead -> stays CRIT; sample 94 -> WARN.
- Two channels reach CRIT on the same sample edge -> crit_events increments by 2. Preload near 0xFFFF and check it saturates at 0xFFFF.
- enable=0 while channels are in WARN/CRIT -> next cycle all flags=0 and monitoring=0; crit_events is retained. With EMISSIONS_CRIT_LATCH_EN: sample 30 with no ack -> CRIT held; ack then sample 30 -> NORMAL.

Source files
------------

// File: rtl/emissions_pkg.sv
// rtl/emissions_pkg.sv - shared level/top-state types and the sample classifier
package emissions_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        WARN   = 2'b01,
        CRIT   = 2'b10
    } level_t;

    typedef enum logic {
        IDLE    = 1'b0,
        MONITOR = 1'b1
    } top_state_t;

    // Thresholds and samples are widened to 32 bits so one function serves any DATA_W <= 32.
    function automatic level_t classify(input logic [31:0] sample,
                                        input logic [31:0] warn_th,
                                        input logic [31:0] crit_th);
        if (sample >= crit_th) begin
            return CRIT;
        end
        if (sample >= warn_th) begin
            return WARN;
        end
        return NORMAL;
    endfunction

endpackage

// File: rtl/emissions_channel.sv
// rtl/emissions_channel.sv - per-channel level FSM with persistence, hysteresis and optional CRIT latch (EMISSIONS_CRIT_LATCH_EN)
module emissions_channel #(
    parameter int DATA_W  = 8,
    parameter int WARN_TH = 50,
    parameter int CRIT_TH = 100,
    parameter int HYST    = 5,
    parameter int PERSIST = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              update,
    input  logic [DATA_W-1:0] sample,
    input  logic              ack,
    output logic [1:0]        level,
    output logic              crit_entry
);
    import emissions_pkg::*;

    localparam int          CW      = $clog2(PERSIST + 1);
    localparam logic [31:0] CRIT_LO = 32'(CRIT_TH - HYST);
    localparam logic [31:0] WARN_LO = 32'(WARN_TH - HYST);

    level_t        lvl, lvl_nxt, raw;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic          ack_seen, ack_nxt;
    logic [31:0]   s32;

    assign s32     = 32'(sample);
    assign raw     = classify(s32, 32'(WARN_TH), 32'(CRIT_TH));
    assign cnt_inc = cnt + 1'b1;

`ifndef EMISSIONS_CRIT_LATCH_EN
    logic ack_unused;
    assign ack_unused = ack;
`endif

    always_comb begin
        lvl_nxt    = lvl;
        cnt_nxt    = cnt;
        ack_nxt    = ack_seen;
        crit_entry = 1'b0;
        if (clear) begin
            lvl_nxt = NORMAL;
            cnt_nxt = '0;
            ack_nxt = 1'b0;
        end else begin
`ifdef EMISSIONS_CRIT_LATCH_EN
            if (lvl == CRIT && ack) begin
                ack_nxt = 1'b1;
            end
`endif
            if (update) begin
                if (raw > lvl) begin
                    if (cnt_inc == CW'(PERSIST)) begin
                        lvl_nxt = raw;
                        cnt_nxt = '0;
                        if (raw == CRIT) begin
                            crit_entry = 1'b1;
                            ack_nxt    = 1'b0;
                        end
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else begin
                    // De-escalation and the hysteresis hold both break the escalation streak.
                    cnt_nxt = '0;
`ifdef EMISSIONS_CRIT_LATCH_EN
                    if (lvl == CRIT && s32 < CRIT_LO && ack_nxt) begin
`else
                    if (lvl == CRIT && s32 < CRIT_LO) begin
`endif
                        lvl_nxt = (s32 < WARN_LO) ? NORMAL : WARN;
                    end else if (lvl == WARN && s32 < WARN_LO) begin
                        lvl_nxt = NORMAL;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lvl      <= NORMAL;
            cnt      <= '0;
            ack_seen <= 1'b0;
        end else begin
            lvl      <= lvl_nxt;
            cnt      <= cnt_nxt;
            ack_seen <= ack_nxt;
        end
    end

    assign level = lvl;

endmodule

// File: rtl/emissions_monitor_mc.sv
// rtl/emissions_monitor_mc.sv - multi-channel emissions monitor top; optional sticky CRIT via EMISSIONS_CRIT_LATCH_EN
module emissions_monitor_mc #(
    parameter int DATA_W  = 8,
    parameter int NUM_CH  = 4,
    parameter int WARN_TH = 50,
    parameter int CRIT_TH = 100,
    parameter int HYST    = 5,
    parameter int PERSIST = 3,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     sample_valid,
    input  logic [NUM_CH*DATA_W-1:0] sample_data,
    input  logic [NUM_CH-1:0]        ack,
    output logic                     monitoring,
    output logic [NUM_CH-1:0]        warning,
    output logic [NUM_CH-1:0]        critical,
    output logic                     any_warning,
    output logic                     any_critical,
    output logic [CNT_W-1:0]         crit_events
);
    import emissions_pkg::*;

    localparam int PW = $clog2(NUM_CH + 1);

    top_state_t state, state_nxt;
    logic       clear, update;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable)  state_nxt = MONITOR;
            MONITOR: if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Disable wins over a coincident sample: channels clear instead of evaluating it.
    assign clear  = (state_nxt == IDLE);
    assign update = (state == MONITOR) && enable && sample_valid;

    logic [NUM_CH-1:0] crit_entry;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0] lvl;
        emissions_channel #(
            .DATA_W (DATA_W),
            .WARN_TH(WARN_TH),
            .CRIT_TH(CRIT_TH),
            .HYST   (HYST),
            .PERSIST(PERSIST)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .clear     (clear),
            .update    (update),
            .sample    (sample_data[i*DATA_W +: DATA_W]),
            .ack       (ack[i]),
            .level     (lvl),
            .crit_entry(crit_entry[i])
        );
        assign warning[i]  = (lvl == WARN);
        assign critical[i] = (lvl == CRIT);
    end

    assign monitoring   = (state == MONITOR);
    assign any_warning  = |warning;
    assign any_critical = |critical;

    logic [PW-1:0]       pop;
    logic [CNT_W+PW-1:0] sum;
    logic [CNT_W-1:0]    events_nxt;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop = pop + PW'(crit_entry[i]);
        end
        sum = {{PW{1'b0}}, crit_events} + {{CNT_W{1'b0}}, pop};
        if (sum > {{PW{1'b0}}, {CNT_W{1'b1}}}) begin
            events_nxt = '1;
        end else begin
            events_nxt = sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crit_events <= '0;
        end else begin
            crit_events <= events_nxt;
        end
    end

endmodule

// File: tb/tb_emissions_monitor_mc.sv
// tb/tb_emissions_monitor_mc.sv - scoreboard bench for emissions_monitor_mc against a behavioural model
module tb_emissions_monitor_mc;

    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 4;
    localparam int PERSIST = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     reset, enable, sample_valid;
    logic [NUM_CH*DATA_W-1:0] sample_data;
    logic [NUM_CH-1:0]        ack;
    logic                     monitoring, any_warning, any_critical;
    logic [NUM_CH-1:0]        warning, critical;
    logic [CNT_W-1:0]         crit_events;

    emissions_monitor_mc #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .ack         (ack),
        .monitoring  (monitoring),
        .warning     (warning),
        .critical    (critical),
        .any_warning (any_warning),
        .any_critical(any_critical),
        .crit_events (crit_events)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              mon;
        logic [NUM_CH-1:0] w;
        logic [NUM_CH-1:0] c;
        logic              aw;
        logic              ac;
        logic [CNT_W-1:0]  ev;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Reference model: levels as 0/1/2, streak counts, ack memory, event total.
    int m_mon;
    int m_lvl[NUM_CH];
    int m_streak[NUM_CH];
    int m_ack[NUM_CH];
    int m_ev;

    function automatic void model_clear_channels();
        for (int i = 0; i < NUM_CH; i++) begin
            m_lvl[i] = 0; m_streak[i] = 0; m_ack[i] = 0;
        end
    endfunction

    function automatic exp_t model_step();
        exp_t e;
        int   entries, s, raw;
        if (reset) begin
            m_mon = 0; m_ev = 0;
            model_clear_channels();
        end else if (m_mon == 0) begin
            if (enable) m_mon = 1;
            model_clear_channels();
        end else if (!enable) begin
            m_mon = 0;
            model_clear_channels();
        end else begin
            entries = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                s = int'(sample_data[i*DATA_W +: DATA_W]);
`ifdef EMISSIONS_CRIT_LATCH_EN
                if (m_lvl[i] == 2 && ack[i]) m_ack[i] = 1;
`endif
                if (sample_valid) begin
                    raw = (s >= 100) ? 2 : (s >= 50) ? 1 : 0;
                    if (raw > m_lvl[i]) begin
                        m_streak[i]++;
                        if (m_streak[i] == PERSIST) begin
                            m_lvl[i] = raw; m_streak[i] = 0;
                            if (raw == 2) begin entries++; m_ack[i] = 0; end
                        end
                    end else begin
                        m_streak[i] = 0;
`ifdef EMISSIONS_CRIT_LATCH_EN
                        if (m_lvl[i] == 2 && s < 95 && m_ack[i] == 1) m_lvl[i] = (s < 45) ? 0 : 1;
`else
                        if (m_lvl[i] == 2 && s < 95) m_lvl[i] = (s < 45) ? 0 : 1;
`endif
                        else if (m_lvl[i] == 1 && s < 45) m_lvl[i] = 0;
                    end
                end
            end
            m_ev = (m_ev + entries > CNT_MAX) ? CNT_MAX : m_ev + entries;
        end
        e.mon = (m_mon == 1);
        for (int i = 0; i < NUM_CH; i++) begin
            e.w[i] = (m_lvl[i] == 1);
            e.c[i] = (m_lvl[i] == 2);
        end
        e.aw = |e.w;
        e.ac = |e.c;
        e.ev = CNT_W'(m_ev);
        return e;
    endfunction

    task automatic step(input logic r, input logic en, input logic v,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3,
                        input logic [3:0] a);
        reset = r; enable = en; sample_valid = v;
        sample_data = {d3, d2, d1, d0}; ack = a;
        exp_q.push_back(model_step());
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_monitoring", 32'(monitoring), 32'(e.mon));
            check("sb_warning", 32'(warning), 32'(e.w));
            check("sb_critical", 32'(critical), 32'(e.c));
            check("sb_any_warning", 32'(any_warning), 32'(e.aw));
            check("sb_any_critical", 32'(any_critical), 32'(e.ac));
            check("sb_crit_events", 32'(crit_events), 32'(e.ev));
        end
    end

    localparam logic [7:0] SAMPLE_TAB [16] = '{0, 30, 44, 45, 46, 49, 50, 60,
                                               94, 95, 96, 99, 100, 120, 200, 255};

    function automatic logic [7:0] rand_sample();
        if ($urandom_range(0, 1) == 0) return SAMPLE_TAB[$urandom_range(0, 15)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        m_mon = 0; m_ev = 0;
        model_clear_channels();

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("rst_monitoring", 32'(monitoring), 0);
        check("rst_events", 32'(crit_events), 0);

        step(0, 1, 1, 60, 0, 0, 0, 0);
        check("enter_monitor", 32'(monitoring), 1);
        step(0, 1, 1, 60, 0, 0, 0, 0);
        step(0, 1, 1, 60, 0, 0, 0, 0);
        check("warn_not_yet", 32'(warning), 0);
        step(0, 1, 1, 60, 0, 0, 0, 0);
        check("warn0_persist", 32'(warning), 32'h1);
        check("warn0_no_events", 32'(crit_events), 0);

        step(0, 1, 1, 60, 120, 0, 0, 0);
        step(0, 1, 1, 60, 120, 0, 0, 0);
        step(0, 1, 1, 60, 40, 0, 0, 0);
        step(0, 1, 1, 60, 120, 0, 0, 0);
        step(0, 1, 1, 60, 120, 0, 0, 0);
        check("crit1_restart", 32'(critical), 0);
        step(0, 1, 1, 60, 120, 0, 0, 0);
        check("crit1_set", 32'(critical), 32'h2);
        check("crit1_events", 32'(crit_events), 1);

        step(0, 1, 1, 47, 120, 0, 0, 0);
        check("warn0_hyst_hold", 32'(warning), 32'h1);
        step(0, 1, 1, 44, 120, 0, 0, 0);
        check("warn0_release", 32'(warning), 0);

        repeat (3) step(0, 1, 1, 0, 120, 120, 0, 0);
        check("crit2_set", 32'(critical), 32'h6);
        step(0, 1, 1, 0, 120, 30, 0, 0);
        check("crit2_to_normal", 32'(critical | warning), 32'h2);
        repeat (3) step(0, 1, 1, 0, 120, 120, 0, 0);
        step(0, 1, 1, 0, 120, 97, 0, 0);
        check("crit2_hyst_hold", 32'(critical), 32'h6);
        step(0, 1, 1, 0, 120, 94, 0, 0);
        check("crit2_to_warn_c", 32'(critical), 32'h2);
        check("crit2_to_warn_w", 32'(warning), 32'h4);
        check("events_before_pair", 32'(crit_events), 3);

        repeat (3) step(0, 1, 1, 0, 120, 120, 120, 0);
        check("pair_crit", 32'(critical), 32'hE);
        check("pair_events", 32'(crit_events), 5);

        step(0, 0, 1, 120, 120, 120, 120, 0);
        check("disable_mon", 32'(monitoring), 0);
        check("disable_flags", 32'({warning, critical, any_warning, any_critical}), 0);
        check("disable_events_kept", 32'(crit_events), 5);

        step(0, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 1, 1, 120, 0, 0, 0, 0);
        check("ch0_crit", 32'(critical), 32'h1);
        step(0, 1, 1, 30, 0, 0, 0, 0);
`ifdef EMISSIONS_CRIT_LATCH_EN
        check("latch_hold_no_ack", 32'(critical), 32'h1);
`else
        check("no_latch_release", 32'(critical), 0);
`endif
        step(0, 1, 0, 0, 0, 0, 0, 4'h1);
        step(0, 1, 1, 30, 0, 0, 0, 0);
        check("ack_then_release", 32'(critical), 0);

        for (int r = 0; r < 4; r++) begin
            repeat (3) step(0, 1, 1, 120, 120, 120, 120, 0);
            step(0, 1, 1, 30, 30, 30, 30, 4'hF);
        end
        check("events_saturate", 32'(crit_events), CNT_MAX);

        for (int n = 0; n < 2500; n++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) != 0),
                 ($urandom_range(0, 3) != 0), rand_sample(), rand_sample(),
                 rand_sample(), rand_sample(),
                 {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)});
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
